button_conditioner: RTL and testbench

// - Front end for the Simon game FSM: takes the four raw pushbuttons and delivers clean, debounced button levels.
// - Its btn output drives the game FSM's btn input directly, so that a held button reads as one stable level, not a burst of bounces.
// - Also emits one-cycle press and release pulses for future consumers.
// - Uses the same ticks_per_milli timebase as the game FSM.

---
 rtl/button_conditioner.sv | 110 +++++++++++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton front end: polarity fix, per-bit synchronizer, shared ms timebase,
// and an independent IDLE/CHECK debounce FSM per button with registered press/release pulses.
module button_conditioner #(
    parameter int N_BTN          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_MS    = 20,
    parameter bit BTN_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ticks_per_milli,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } db_state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_MS - 1);

    logic [N_BTN-1:0] raw_pol;
    logic [N_BTN-1:0] sync_q [SYNC_STAGES];
    logic [N_BTN-1:0] s;
    logic [15:0]      tick_cnt;
    logic             ms_tick;
    db_state_t        state [N_BTN];
    logic [7:0]       cnt   [N_BTN];

    // After this inversion 1 always means pressed, so reset loads 0 everywhere.
    assign raw_pol = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= raw_pol;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // >= rather than == so a lowered period takes effect at once instead of wrapping.
    assign ms_tick = (tick_cnt >= ticks_per_milli);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (ms_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn         <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                case (state[i])
                    IDLE: begin
                        cnt[i] <= '0;
                        if (s[i] != btn[i]) begin
                            state[i] <= CHECK;
                        end
                    end
                    CHECK: begin
                        // A bounce back to the accepted level wins over a coincident tick.
                        if (s[i] == btn[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (ms_tick) begin
                            if (cnt[i] == DB_LAST) begin
                                btn[i]         <= s[i];
                                btn_press[i]   <= s[i];
                                btn_release[i] <= ~s[i];
                                cnt[i]         <= '0;
                                state[i]       <= IDLE;
                            end else begin
                                cnt[i] <= cnt[i] + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: 10 cycles/ms, 4 ms debounce, 2 sync stages.
module tb_button_conditioner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tpm = 16'd9;
    logic [3:0]  raw = 4'b1111;
    logic [3:0]  btn, btn_press, btn_release;

    int checks = 0;
    int errors = 0;
    int model_err = 0;
    int n;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [3:0] btn_prev = 4'b0000;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_MS(4),
        .BTN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ticks_per_milli(tpm),
        .btn_raw(raw),
        .btn(btn),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulses must coincide exactly with level changes of btn.
    always @(negedge clk) begin
        if ({btn_release, btn_press} != 8'h00) got_q.push_back({btn_release, btn_press});
        if (btn_press !== (btn & ~btn_prev) || btn_release !== (~btn & btn_prev)) model_err++;
        btn_prev = btn;
    end

    task automatic wait_bits(input logic [3:0] mask, input logic [3:0] val, input int max_cyc,
                             output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (((btn & mask) !== (val & mask)) && cyc <= max_cyc);
    endtask

    function automatic int clamp_win(input int c);
        if (c < 34) return 34;
        if (c > 43) return 43;
        return c;
    endfunction

    task automatic drain(input string tag);
        #1;
        check({tag, "_events"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_event"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every button held
        repeat (3) begin
            @(negedge clk);
            check("rst_outs", {btn, btn_press, btn_release}, 12'h000);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_after", {btn, btn_press, btn_release}, 12'h000);
        wait_bits(4'hf, 4'hf, 100, n);
        n = n + 1;
        check("held_lat", n, clamp_win(n));
        check("held_btn", btn, 4'hf);
        exp_q.push_back({4'h0, 4'hf});
        raw = 4'b0000;
        wait_bits(4'hf, 4'h0, 100, n);
        check("held_rel_lat", n, clamp_win(n));
        exp_q.push_back({4'hf, 4'h0});
        drain("held");

        // Clean press on button 0
        raw = 4'b0001;
        wait_bits(4'h1, 4'h1, 100, n);
        check("press0_lat", n, clamp_win(n));
        repeat (50) @(negedge clk);
        check("press0_hold", btn, 4'h1);
        exp_q.push_back({4'h0, 4'h1});
        drain("press0");

        // Short pulse on button 2 is rejected, a long one is accepted
        raw = 4'b0101;
        repeat (25) @(negedge clk);
        raw = 4'b0001;
        repeat (60) @(negedge clk);
        check("bounce_btn", btn, 4'h1);
        drain("bounce");
        raw = 4'b0101;
        repeat (60) @(negedge clk);
        check("bounce_hold_btn", btn, 4'h5);
        exp_q.push_back({4'h0, 4'h4});
        drain("bounce_hold");

        // Release button 0, then button 2
        raw = 4'b0100;
        wait_bits(4'h1, 4'h0, 100, n);
        check("rel0_lat", n, clamp_win(n));
        check("rel0_btn", btn, 4'h4);
        exp_q.push_back({4'h1, 4'h0});
        raw = 4'b0000;
        wait_bits(4'h4, 4'h0, 100, n);
        check("rel2_btn", btn, 4'h0);
        exp_q.push_back({4'h4, 4'h0});
        drain("release");

        // Buttons 1 and 3 together
        raw = 4'b1010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((btn & 4'ha) == 4'h0 && n <= 100);
        check("simul_btn", btn, 4'ha);
        check("simul_lat", n, clamp_win(n));
        exp_q.push_back({4'h0, 4'ha});
        raw = 4'b0000;
        wait_bits(4'ha, 4'h0, 100, n);
        check("simul_rel_btn", btn, 4'h0);
        exp_q.push_back({4'ha, 4'h0});
        drain("simul");

        // One-cycle glitch on button 1 restarts only its debounce
        raw = 4'b1010;
        repeat (15) @(negedge clk);
        raw = 4'b1000;
        @(negedge clk);
        raw = 4'b1010;
        wait_bits(4'h8, 4'h8, 100, n);
        n = n + 16;
        check("glitch_b3_lat", n, clamp_win(n));
        check("glitch_b1_low", btn, 4'h8);
        exp_q.push_back({4'h0, 4'h8});
        wait_bits(4'h2, 4'h2, 100, n);
        check("glitch_b1_late", btn, 4'ha);
        exp_q.push_back({4'h0, 4'h2});
        raw = 4'b0000;
        wait_bits(4'ha, 4'h0, 100, n);
        check("glitch_rel_btn", btn, 4'h0);
        exp_q.push_back({4'ha, 4'h0});
        drain("glitch");

        // Tick every cycle
        tpm = 16'd0;
        raw = 4'b0001;
        wait_bits(4'h1, 4'h1, 50, n);
        check("tpm0_press", n, 7);
        raw = 4'b0000;
        wait_bits(4'h1, 4'h0, 50, n);
        check("tpm0_release", n, 7);
        exp_q.push_back({4'h0, 4'h1});
        exp_q.push_back({4'h1, 4'h0});

        // Shorten the period mid-count: tick_cnt=20 >= 5 ticks at once, then every 6 cycles
        tpm = 16'd1000;
        raw = 4'b0001;
        repeat (20) @(negedge clk);
        check("tpm_switch_pre", btn, 4'h0);
        tpm = 16'd5;
        wait_bits(4'h1, 4'h1, 100, n);
        check("tpm_switch_lat", n + 20, 39);
        exp_q.push_back({4'h0, 4'h1});
        raw = 4'b0000;
        wait_bits(4'h1, 4'h0, 100, n);
        check("tpm_switch_rel", btn, 4'h0);
        exp_q.push_back({4'h1, 4'h0});
        drain("timebase");

        // Reset mid-debounce discards the partial count
        tpm = 16'd9;
        raw = 4'b0001;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_outs", {btn, btn_press, btn_release}, 12'h000);
        rst = 1'b0;
        wait_bits(4'h1, 4'h1, 100, n);
        check("rst_mid_lat", n, clamp_win(n));
        exp_q.push_back({4'h0, 4'h1});
        raw = 4'b0000;
        wait_bits(4'h1, 4'h0, 100, n);
        check("rst_mid_rel", btn, 4'h0);
        exp_q.push_back({4'h1, 4'h0});
        drain("rst_mid");

        check("pulse_model", model_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
